// File: rtl/hssl_link_monitor.sv
// Multi-lane HSSL receive bring-up/health monitor: per-lane reset, alignment, leaky error integrator.
// Optional statistics counters are built only when HSSL_LINK_STATS_EN is defined.
module hssl_link_lane #(
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 4096,
  parameter int GOOD_WORDS   = 64,
  parameter int ERR_THRESH   = 8,
  parameter int ERR_DECAY    = 1024,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             reset_done,
  input  logic [3:0]       charisk,
  input  logic [3:0]       disperr,
  input  logic [3:0]       encerr,
  input  logic             bufstatus,
  input  logic             clear,
  output logic             reset_datapath,
  output logic             lane_up,
  output logic [1:0]       state_enc,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] retrain_cnt
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_ALIGN = 2'd2,
    S_UP    = 2'd3
  } state_t;

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DONE_TIMEOUT + 1);
  localparam int GW = $clog2(GOOD_WORDS + 1);
  localparam int LW = $clog2(ERR_THRESH + 1);
  localparam int KW = $clog2(ERR_DECAY + 1);

  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD       = GW'(GOOD_WORDS);
  localparam logic [LW-1:0] THRESH     = LW'(ERR_THRESH);
  localparam logic [KW-1:0] DECAY_LAST = KW'(ERR_DECAY - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] rst_cnt, rst_cnt_nxt;
  logic [DW-1:0] done_cnt, done_cnt_nxt;
  logic [GW-1:0] run, run_nxt;
  logic [LW-1:0] lvl, lvl_nxt;
  logic [KW-1:0] decay;
  logic          err_word, tick, retrain_ev, err_ev;

  assign err_word = (|disperr) | (|encerr) | bufstatus;
  assign tick     = (decay == DECAY_LAST);
  assign err_ev   = err_word & ((state == S_ALIGN) | (state == S_UP));

  always_comb begin
    state_nxt    = state;
    rst_cnt_nxt  = rst_cnt;
    done_cnt_nxt = done_cnt;
    run_nxt      = run;
    lvl_nxt      = lvl;
    retrain_ev   = 1'b0;
    case (state)
      S_RESET: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt   = S_WAIT;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (reset_done) begin
          state_nxt    = S_ALIGN;
          done_cnt_nxt = '0;
        end else if (done_cnt == DONE_LAST) begin
          state_nxt    = S_RESET;
          done_cnt_nxt = '0;
          retrain_ev   = 1'b1;
        end else begin
          done_cnt_nxt = done_cnt + 1'b1;
        end
      end
      S_ALIGN: begin
        // A run may only start on a comma-bearing clean word.
        if (err_word)          run_nxt = '0;
        else if (run != '0)    run_nxt = run + 1'b1;
        else if (|charisk)     run_nxt = GW'(1);
        if (run_nxt == GOOD) begin
          state_nxt = S_UP;
          run_nxt   = '0;
          lvl_nxt   = '0;
        end
      end
      S_UP: begin
        // Coincident error and decay tick cancel out.
        if (err_word && !tick) begin
          if (lvl != THRESH) lvl_nxt = lvl + 1'b1;
        end else if (tick && !err_word && lvl != '0) begin
          lvl_nxt = lvl - 1'b1;
        end
        if (lvl_nxt == THRESH) begin
          state_nxt  = S_RESET;
          retrain_ev = 1'b1;
        end
      end
      default: state_nxt = S_RESET;
    endcase

    if (!enable) begin
      state_nxt    = S_RESET;
      rst_cnt_nxt  = '0;
      done_cnt_nxt = '0;
      run_nxt      = '0;
      retrain_ev   = 1'b0;
    end else if (!reset_done && (state == S_ALIGN || state == S_UP)) begin
      state_nxt  = S_RESET;
      run_nxt    = '0;
      retrain_ev = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_RESET;
      rst_cnt        <= '0;
      done_cnt       <= '0;
      run            <= '0;
      lvl            <= '0;
      decay          <= '0;
      reset_datapath <= 1'b1;
      lane_up        <= 1'b0;
    end else begin
      state          <= state_nxt;
      rst_cnt        <= rst_cnt_nxt;
      done_cnt       <= done_cnt_nxt;
      run            <= run_nxt;
      lvl            <= lvl_nxt;
      decay          <= tick ? '0 : decay + 1'b1;
      reset_datapath <= (state_nxt == S_RESET);
      lane_up        <= (state_nxt == S_UP);
    end
  end

  assign state_enc = state;

`ifdef HSSL_LINK_STATS_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      retrain_cnt <= '0;
    end else if (clear) begin
      err_cnt     <= '0;
      retrain_cnt <= '0;
    end else begin
      if (err_ev && err_cnt != CMAX)         err_cnt     <= err_cnt + 1'b1;
      if (retrain_ev && retrain_cnt != CMAX) retrain_cnt <= retrain_cnt + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{clear, retrain_ev, err_ev};
  assign err_cnt      = '0;
  assign retrain_cnt  = '0;
`endif

endmodule

module hssl_link_monitor #(
  parameter int NUM_LANES    = 4,
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 4096,
  parameter int GOOD_WORDS   = 64,
  parameter int ERR_THRESH   = 8,
  parameter int ERR_DECAY    = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic [NUM_LANES-1:0]       lane_enable_in,
  input  logic [NUM_LANES-1:0]       rx_reset_done_in,
  input  logic [4*NUM_LANES-1:0]     rx_charisk_in,
  input  logic [4*NUM_LANES-1:0]     rx_disperr_in,
  input  logic [4*NUM_LANES-1:0]     rx_encerr_in,
  input  logic [NUM_LANES-1:0]       rx_bufstatus_in,
  input  logic                       counters_clear_in,
  output logic [NUM_LANES-1:0]       rx_reset_datapath_out,
  output logic [NUM_LANES-1:0]       lane_up_out,
  output logic [2*NUM_LANES-1:0]     state_out,
  output logic [CNT_W*NUM_LANES-1:0] err_count_out,
  output logic [CNT_W*NUM_LANES-1:0] retrain_count_out
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hssl_link_lane #(
      .RST_CYCLES  (RST_CYCLES),
      .DONE_TIMEOUT(DONE_TIMEOUT),
      .GOOD_WORDS  (GOOD_WORDS),
      .ERR_THRESH  (ERR_THRESH),
      .ERR_DECAY   (ERR_DECAY),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk           (clk_in),
      .rst_n         (reset_n_in),
      .enable        (lane_enable_in[i]),
      .reset_done    (rx_reset_done_in[i]),
      .charisk       (rx_charisk_in[4*i +: 4]),
      .disperr       (rx_disperr_in[4*i +: 4]),
      .encerr        (rx_encerr_in[4*i +: 4]),
      .bufstatus     (rx_bufstatus_in[i]),
      .clear         (counters_clear_in),
      .reset_datapath(rx_reset_datapath_out[i]),
      .lane_up       (lane_up_out[i]),
      .state_enc     (state_out[2*i +: 2]),
      .err_cnt       (err_count_out[CNT_W*i +: CNT_W]),
      .retrain_cnt   (retrain_count_out[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_hssl_link_monitor.sv
// Scoreboard bench for hssl_link_monitor: expectations queued at stimulus, popped when output is observed.
module tb_hssl_link_monitor;
  localparam int NL = 4;
  localparam int CW = 16;
  localparam int PERIOD = 16 + 4096;
`ifdef HSSL_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NL-1:0]    en, done, bufst;
  logic [4*NL-1:0]  kk, de, ee;
  logic             clr;
  logic [NL-1:0]    rdp, up;
  logic [2*NL-1:0]  st;
  logic [CW*NL-1:0] errc, retc;

  hssl_link_monitor #(.NUM_LANES(NL)) dut (
    .clk_in               (clk),
    .reset_n_in           (reset_n),
    .lane_enable_in       (en),
    .rx_reset_done_in     (done),
    .rx_charisk_in        (kk),
    .rx_disperr_in        (de),
    .rx_encerr_in         (ee),
    .rx_bufstatus_in      (bufst),
    .counters_clear_in    (clr),
    .rx_reset_datapath_out(rdp),
    .lane_up_out          (up),
    .state_out            (st),
    .err_count_out        (errc),
    .retrain_count_out    (retc)
  );

  always #5 clk = ~clk;

  int ecnt;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp, got;

  function automatic logic [63:0] sv(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = '1; done = '0; bufst = '0;
    kk = '0; de = '0; ee = '0; clr = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  task automatic wait_up(input int lane, input int bound, output int n);
    n = 0;
    while (!up[lane] && n < bound) begin step(1); n++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = '1; done = '0; bufst = '0;
    kk = '0; de = '0; ee = '0; clr = 1'b0;
    exp_q.push_back(64'hF); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    step(2);
    exp = exp_q.pop_front(); got = 64'(rdp); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_rdp got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = 64'(up); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_up got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = 64'(st); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_state got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = errc; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_errcnt got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = retc; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_retrain got %0h exp %0h", got, exp); end
  endtask

  task automatic test_bring_up();
    int w[NL];
    int n;
    do_reset();
    for (int l = 0; l < NL; l++) begin w[l] = 0; exp_q.push_back(64'd16); end
    for (int c = 0; c < 100; c++) begin
      if (c == 36) done = '1;
      for (int l = 0; l < NL; l++) if (rdp[l]) w[l]++;
      step(1);
    end
    for (int l = 0; l < NL; l++) begin
      exp = exp_q.pop_front(); got = 64'(w[l]); checks++;
      if (got !== exp) begin errors++; $display("FAIL bringup_pulse_len lane %0d got %0d exp %0d", l, got, exp); end
    end
    kk = {NL{4'b0001}};
    exp_q.push_back(64'd64); exp_q.push_back(64'hF);
    step(1);
    kk = '0;
    n = 1;
    while (up != '1 && n < 200) begin step(1); n++; end
    exp = exp_q.pop_front(); got = 64'(n); checks++;
    if (got !== exp) begin errors++; $display("FAIL bringup_up_latency got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(up); checks++;
    if (got !== exp) begin errors++; $display("FAIL bringup_up got %0h exp %0h", got, exp); end
    exp_q.push_back(64'h0);
    got = errc | retc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bringup_counters got %0h exp %0h", got, exp); end
    // asynchronous reset mid-operation
    @(posedge clk); #2;
    reset_n = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back(64'hF);
    #1;
    exp = exp_q.pop_front(); got = 64'(st); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_state got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = 64'(rdp); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_rdp got %0h exp %0h", got, exp); end
  endtask

  task automatic test_timeout();
    int t;
    logic prev;
    do_reset();
    kk = {NL{4'b0001}};
    step(20);
    done = 4'b1101;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(64'(PERIOD * k)); exp_q.push_back(sv(k)); exp_q.push_back(64'h0);
      t = 0; prev = rdp[1];
      while (t < 5000) begin
        step(1); t++;
        if (rdp[1] && !prev) break;
        prev = rdp[1];
      end
      exp = exp_q.pop_front(); got = 64'(ecnt); checks++;
      if (t >= 5000 || got !== exp) begin errors++; $display("FAIL timeout_reentry %0d got %0d exp %0d", k, got, exp); end
      exp = exp_q.pop_front(); got = 64'(retc[CW +: CW]); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_retrain %0d got %0d exp %0d", k, got, exp); end
      exp = exp_q.pop_front(); got = 64'(st[3:2]); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_state %0d got %0d exp %0d", k, got, exp); end
    end
    exp_q.push_back(64'b1101); exp_q.push_back(64'h0);
    exp = exp_q.pop_front(); got = 64'(up); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_other_lanes_up got %0h exp %0h", got, exp); end
    exp = exp_q.pop_front(); got = 64'({retc[3*CW +: CW], retc[2*CW +: CW], retc[0 +: CW]}); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_other_retrain got %0h exp %0h", got, exp); end
  endtask

  task automatic test_align_break();
    int n;
    do_reset();
    step(20);
    done = '1;
    step(5);
    kk = {NL{4'b0001}}; step(1); kk = '0;
    step(39);
    de = {NL{4'b0010}}; step(1); de = '0;
    exp_q.push_back(64'h0);
    step(200);
    exp = exp_q.pop_front(); got = 64'(up); checks++;
    if (got !== exp) begin errors++; $display("FAIL align_no_up_without_comma got %0h exp %0h", got, exp); end
    kk = {NL{4'b0001}};
    exp_q.push_back(64'd64); exp_q.push_back(sv(1));
    step(1); kk = '0;
    n = 1;
    while (!up[0] && n < 200) begin step(1); n++; end
    exp = exp_q.pop_front(); got = 64'(n); checks++;
    if (got !== exp) begin errors++; $display("FAIL align_relock_latency got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(errc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL align_errcnt got %0d exp %0d", got, exp); end
  endtask

  task automatic test_leaky();
    int drops = 0;
    int t;
    exp_q.push_back(64'h0);
    for (int i = 0; i < 4; i++) begin
      de[3:0] = 4'b0010; step(1); de[3:0] = 4'b0000;
      for (int c = 0; c < 2047; c++) begin
        if (!up[0]) drops++;
        step(1);
      end
    end
    exp = exp_q.pop_front(); got = 64'(drops); checks++;
    if (got !== exp) begin errors++; $display("FAIL leaky_stays_up drops %0d exp %0d", got, exp); end
    // start the burst clear of any decay tick so eight errors exactly reach threshold
    step(1100);
    t = 0;
    while ((ecnt % 1024) != 100 && t < 2048) begin step(1); t++; end
    for (int j = 1; j <= 8; j++) begin
      de[3:0] = 4'b0010;
      exp_q.push_back(j < 8 ? 64'd1 : 64'd0);
      step(1);
      exp = exp_q.pop_front(); got = 64'(up[0]); checks++;
      if (got !== exp) begin errors++; $display("FAIL leaky_burst_up err %0d got %0d exp %0d", j, got, exp); end
    end
    de = '0;
    exp_q.push_back(64'h0); exp_q.push_back(sv(1)); exp_q.push_back(sv(13)); exp_q.push_back(64'b1110);
    exp = exp_q.pop_front(); got = 64'(st[1:0]); checks++;
    if (got !== exp) begin errors++; $display("FAIL leaky_burst_state got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(retc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL leaky_retrain got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(errc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL leaky_errcnt got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(up); checks++;
    if (got !== exp) begin errors++; $display("FAIL leaky_other_lanes got %0h exp %0h", got, exp); end
  endtask

  task automatic test_overrides();
    int n;
    kk = {NL{4'b0001}};
    done = '1;
    wait_up(0, 300, n);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ovr_relock1 got %0d exp <300", n); end
    en[0] = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(sv(1));
    step(1);
    exp = exp_q.pop_front(); got = 64'(st[1:0]); checks++;
    if (got !== exp) begin errors++; $display("FAIL ovr_enable_state got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(up[0]); checks++;
    if (got !== exp) begin errors++; $display("FAIL ovr_enable_up got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(retc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL ovr_enable_retrain got %0d exp %0d", got, exp); end
    en[0] = 1'b1;
    wait_up(0, 300, n);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ovr_relock2 got %0d exp <300", n); end
    done[0] = 1'b0;
    exp_q.push_back(64'h0); exp_q.push_back(sv(2));
    step(1);
    exp = exp_q.pop_front(); got = 64'(st[1:0]); checks++;
    if (got !== exp) begin errors++; $display("FAIL ovr_done_state got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = 64'(retc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL ovr_done_retrain got %0d exp %0d", got, exp); end
    done[0] = 1'b1;
    wait_up(0, 300, n);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ovr_relock3 got %0d exp <300", n); end
    clr = 1'b1; de[3:0] = 4'b0010;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    step(1);
    clr = 1'b0;
    exp = exp_q.pop_front(); got = 64'(errc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_vs_err_errcnt got %0d exp %0d", got, exp); end
    exp = exp_q.pop_front(); got = retc; checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_retrain got %0h exp %0h", got, exp); end
    exp_q.push_back(sv(1));
    step(1);
    de = '0;
    exp = exp_q.pop_front(); got = 64'(errc[0 +: CW]); checks++;
    if (got !== exp) begin errors++; $display("FAIL errcnt_after_clear got %0d exp %0d", got, exp); end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_timeout();
    test_align_break();
    test_leaky();
    test_overrides();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hssl_link_monitor.md
# hssl_link_monitor

Multi-lane receive link bring-up and health monitor for the HSSL transceiver path. One instance sits beside the Gigabit transceiver wrapper(s) and supervises `NUM_LANES` receive lanes in the `rx_usrclk2` domain. Each lane follows the same sequence: datapath reset, wait for reset-done, qualify 8b/10b alignment over a run of clean words, then declare the lane up. A leaky error integrator retrains the lane when link quality degrades.

## Interface
Parameters:
- `NUM_LANES`, 4: number of supervised receive lanes (1–16).
- `RST_CYCLES`, 16: cycles `rx_reset_datapath` is held per reset pulse (≥1).
- `DONE_TIMEOUT`, 4096: cycles allowed for `rx_reset_done` before the lane re-enters reset.
- `GOOD_WORDS`, 64: consecutive clean words required to declare the lane up (≥1).
- `ERR_THRESH`, 8: error-level value that forces a retrain (≥1).
- `ERR_DECAY`, 1024: period of the error-level decrement tick.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk_in`, in, 1: single clock, the shared `rx_usrclk2`. All inputs are synchronous to it.
- `reset_n_in`, in, 1: asynchronous, active-low reset.
- `lane_enable_in`, in, NUM_LANES: per-lane enable. 0 holds the lane in RESET.
- `rx_reset_done_in`, in, NUM_LANES: transceiver rx reset done, per lane.
- `rx_charisk_in`, in, 4*NUM_LANES: K-character flags. Lane i uses bits [4i+3:4i].
- `rx_disperr_in`, in, 4*NUM_LANES: disparity error flags.
- `rx_encerr_in`, in, 4*NUM_LANES: not-in-table (encoding) error flags.
- `rx_bufstatus_in`, in, NUM_LANES: elastic buffer over/underflow flag.
- `counters_clear_in`, in, 1: synchronous clear of all statistics counters.
- `rx_reset_datapath_out`, out, NUM_LANES: drives the transceiver `gtwiz_reset_rx_datapath` input.
- `lane_up_out`, out, NUM_LANES: lane is qualified and healthy.
- `state_out`, out, 2*NUM_LANES: per-lane FSM state encoding.
- `err_count_out`, out, CNT_W*NUM_LANES: count of erroneous words.
- `retrain_count_out`, out, CNT_W*NUM_LANES: count of entries into RESET from WAIT_DONE, ALIGN or UP.

## Operation
Lanes are fully independent. All per-lane logic is replicated with a generate loop.

Word classification, per lane, per cycle:
- **Error word:** any `disperr` bit, any `encerr` bit, or `bufstatus` set.
- **Clean word:** not an error word.

FSM states and encoding:
- **RESET (0):** `rx_reset_datapath`=1.
  - The counter runs `RST_CYCLES`, then the lane moves to WAIT_DONE.
  - While `lane_enable`=0 the counter is held at 0.
- **WAIT_DONE (1):** `rx_reset_datapath`=0.
  - `rx_reset_done`=1 moves the lane to ALIGN.
  - After `DONE_TIMEOUT` cycles without it, the lane moves to RESET and the retrain count increments.
- **ALIGN (2):** maintains a run counter.
  - Clean word with any `charisk` bit set while run=0: run becomes 1.
  - Clean word while run>0: run increments.
  - Error word: run becomes 0.
  - When run reaches `GOOD_WORDS`, the lane moves to UP and the error level is set to 0.
- **UP (3):** `lane_up`=1.
  - Error word: error level increments, saturating at `ERR_THRESH`.
  - Decay tick (free-running `ERR_DECAY` counter per lane): error level decrements if >0.
  - Error and tick in the same cycle: level unchanged.
  - Level reaching `ERR_THRESH` moves the lane to RESET and the retrain count increments.

Global overrides, highest priority first:
- `lane_enable`=0 in any state: next state RESET. No retrain increment.
- `rx_reset_done`=0 in ALIGN or UP: next state RESET, retrain count increments.

Counters:
- Both statistics counters saturate at 2^CNT_W−1.
- The error counter increments on error words in ALIGN and UP only.
- `counters_clear_in` has priority over an increment in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `rx_reset_datapath_out` all ones, `lane_up_out` 0, `state_out` 0 (RESET), counters 0, all internal counters 0.
- Latency: one cycle from the qualifying input to the state/output change.
  - `lane_up` rises on the cycle after the `GOOD_WORDS`-th clean word is sampled.
  - `lane_up` falls on the cycle after the error word that reaches threshold.
- Reset pulse: `rx_reset_datapath` is high for exactly `RST_CYCLES` cycles after reset deassertion, or after re-entry into RESET with enable high.
- Asserting `reset_n_in` mid-operation immediately forces all lanes to RESET.

## Configuration
- `HSSL_LINK_STATS_EN` defined: `err_count_out` and `retrain_count_out` are implemented as specified.
- Undefined: both outputs are tied to 0, no counter registers are instantiated, and `counters_clear_in` is ignored. FSM behaviour is identical in both builds.

## Test plan
- **Bring-up:** `NUM_LANES`=4, defaults, all enabled. `rx_reset_done` rises 20 cycles after the reset pulse; feed K28.5 then clean words.
  - Required: reset pulse of exactly 16 cycles per lane; `lane_up` high exactly 64 cycles after the first comma word; counters 0.
- **Timeout:** lane 1 `rx_reset_done` held 0.
  - Required: lane 1 re-enters RESET every 16+4096 cycles with `retrain_count`=1, 2, 3…; lanes 0, 2 and 3 unaffected.
- **Alignment run broken:** one `disperr` word after 40 clean words in ALIGN.
  - Required: run restarts; `lane_up` only after a further comma plus 64 clean words; `err_count`=1.
- **Leaky integrator:** in UP, inject one error every 2048 cycles.
  - Required: lane stays up.
  - Then inject 8 errors within 100 cycles; required: `lane_up` falls the cycle after the 8th, state RESET, `retrain_count` increments.
- **Overrides:** drop `lane_enable` in UP.
  - Required: RESET next cycle, `retrain_count` unchanged.
  - Drop `rx_reset_done` in UP; required: RESET and `retrain_count` +1.
  - Assert `counters_clear_in` together with an error word; required: `err_count`=0.
- **Stats compiled out:** rerun the timeout scenario without `HSSL_LINK_STATS_EN`.
  - Required: identical `state_out`/`lane_up_out`; `retrain_count_out`=0.
